pc_ctrl: RTL

Next-PC sequencer for the single-cycle core. It drives the `jump_en`/`jump_pc` inputs of the PC generator and owns the instruction-fetch handshake. It arbitrates between the redirect sources (trap, interrupt, mret, branch/jump) and holds the PC during fetch stalls, boot and halt. It also keeps the retired-instruction counter.

---
 rtl/pc_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pc_ctrl.sv
// Next-PC sequencer: drives the PC generator's jump interface, owns the fetch
// handshake, arbitrates redirect sources and counts retired instructions.
module pc_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_i,
    output logic        jump_en_o,
    output logic [63:0] jump_pc_o,
    output logic        fetch_valid_o,
    input  logic        fetch_ready_i,
    input  logic        br_en_i,
    input  logic [63:0] br_pc_i,
    input  logic        trap_en_i,
    input  logic [63:0] trap_pc_i,
    input  logic        mret_en_i,
    input  logic [63:0] mret_pc_i,
    input  logic        halt_req_i,
    input  logic        irq_i,
    output logic        irq_taken_o,
    output logic        misalign_o,
    output logic        halted_o,
    output logic [63:0] instret_o
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } state_e;

    localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic        irq_pending_q, irq_pending_d;
    logic [63:0] instret_q, instret_d;

    logic        commit;
    logic        irq_take;
    logic        redirect;
    logic [63:0] target;

    // Commit decode and redirect arbitration; everything defaults to a self-jump hold.
    always_comb begin
        commit        = (state_q == StRun) && fetch_ready_i && !rst;
        fetch_valid_o = (state_q == StRun) && !rst;
        halted_o      = (state_q == StHalt) && !rst;
        jump_en_o     = 1'b1;
        jump_pc_o     = pc_i;
        irq_take      = 1'b0;
        redirect      = 1'b0;
        target        = pc_i;
        misalign_o    = 1'b0;

        if (commit) begin
            if (halt_req_i) begin
                // Self-jump: the halting instruction's PC stays put.
                redirect = 1'b0;
            end else if (trap_en_i) begin
                redirect = 1'b1;
                target   = trap_pc_i;
            end else if (irq_pending_q) begin
                redirect = 1'b1;
                target   = trap_pc_i;
                irq_take = 1'b1;
            end else if (mret_en_i) begin
                redirect = 1'b1;
                target   = mret_pc_i;
            end else if (br_en_i) begin
                redirect = 1'b1;
                target   = br_pc_i;
            end else begin
                // Sequential: let the PC generator add 4.
                jump_en_o = 1'b0;
            end
        end

        if (redirect) begin
            jump_pc_o  = {target[63:2], 2'b00};
            misalign_o = |target[1:0];
        end

        irq_taken_o = irq_take;
    end

    // Next-state for the sequencer FSM and boot counter.
    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        unique case (state_q)
            StBoot: begin
                if (boot_cnt_q == BootLast) begin
                    state_d = StRun;
                end else begin
                    boot_cnt_d = boot_cnt_q + 4'd1;
                end
            end
            StRun: begin
                if (commit && halt_req_i) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // Interrupt latch and retired-instruction counter next values.
    always_comb begin
        // A new request in the take cycle keeps the latch set.
        irq_pending_d = (irq_pending_q && !irq_take) || irq_i;
        instret_d     = instret_q + (commit ? 64'd1 : 64'd0);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            boot_cnt_q    <= 4'd0;
            irq_pending_q <= 1'b0;
            instret_q     <= 64'd0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            irq_pending_q <= irq_pending_d;
            instret_q     <= instret_d;
        end
    end

    assign instret_o = instret_q;

    // The PC generator must not move while the core is still booting.
    a_boot_pc: assert property (@(posedge clk) disable iff (rst)
        (state_q == StBoot) |-> (pc_i == RESET_PC));

    // Misalignment is only reported alongside a real jump.
    a_misalign_jump: assert property (@(posedge clk) disable iff (rst)
        misalign_o |-> jump_en_o);

    // No fetch request while halted.
    a_halt_nofetch: assert property (@(posedge clk) disable iff (rst)
        halted_o |-> !fetch_valid_o);

endmodule
